// File: rtl/muldiv_pkg.sv
// Shared definitions for the multiply/divide engine.
// Op codes, FSM state encoding and default cycle counts.
package muldiv_pkg;

    localparam logic [1:0] OP_NONE = 2'b00;
    localparam logic [1:0] OP_MUL  = 2'b01;
    localparam logic [1:0] OP_DIV  = 2'b10;

    localparam int MUL_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF = 10;
    localparam int CNT_W_DEF      = 4;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage

// File: rtl/muldiv_if.sv
// Request/response handshake bundle for the multiply/divide engine.
// The master is the HI/LO wrapper and the slave is the engine.
interface muldiv_if;

    logic [31:0] in_src0;
    logic [31:0] in_src1;
    logic [1:0]  in_op;
    logic        in_sign;
    logic        in_valid;
    logic        in_ready;
    logic        out_ready;
    logic        out_valid;
    logic [31:0] out_res0;
    logic [31:0] out_res1;

    modport master (
        output in_src0, in_src1, in_op, in_sign, in_valid, out_ready,
        input  in_ready, out_valid, out_res0, out_res1
    );

    modport slave (
        input  in_src0, in_src1, in_op, in_sign, in_valid, out_ready,
        output in_ready, out_valid, out_res0, out_res1
    );

endinterface

// File: rtl/muldiv_arith.sv
// Combinational 32x32 multiply and divide producing {hi, lo}.
// Signed divide works on magnitudes, then restores the signs.
module muldiv_arith
    import muldiv_pkg::*;
(
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic [1:0]  i_op,
    input  logic        i_sign,
    output logic [31:0] o_hi,
    output logic [31:0] o_lo
);

    logic [63:0] w_ext_a;
    logic [63:0] w_ext_b;
    logic [63:0] w_prod;
    logic        w_neg_a;
    logic        w_neg_b;
    logic [31:0] w_mag_a;
    logic [31:0] w_mag_b;
    logic [31:0] w_div_b;
    logic [31:0] w_uq;
    logic [31:0] w_ur;
    logic [31:0] w_q;
    logic [31:0] w_r;

    // Low 64 bits of the product are exact for both extension kinds.
    assign w_ext_a = {{32{i_sign & i_a[31]}}, i_a};
    assign w_ext_b = {{32{i_sign & i_b[31]}}, i_b};
    assign w_prod  = w_ext_a * w_ext_b;

    assign w_neg_a = i_sign & i_a[31];
    assign w_neg_b = i_sign & i_b[31];
    assign w_mag_a = w_neg_a ? (~i_a + 32'd1) : i_a;
    assign w_mag_b = w_neg_b ? (~i_b + 32'd1) : i_b;
    assign w_div_b = (w_mag_b == 32'd0) ? 32'd1 : w_mag_b;
    assign w_uq    = w_mag_a / w_div_b;
    assign w_ur    = w_mag_a % w_div_b;

    // 0x80000000 / -1 falls out as 0x80000000 rem 0 from the magnitude path.
    always_comb begin
        w_q = (w_neg_a ^ w_neg_b) ? (~w_uq + 32'd1) : w_uq;
        w_r = w_neg_a ? (~w_ur + 32'd1) : w_ur;
        if (i_b == 32'd0) begin
            w_q = 32'hFFFF_FFFF;
            w_r = i_a;
        end
    end

    always_comb begin
        o_hi = 32'd0;
        o_lo = 32'd0;
        unique case (1'b1)
            (i_op == OP_MUL): begin
                o_hi = w_prod[63:32];
                o_lo = w_prod[31:0];
            end
            (i_op == OP_DIV): begin
                o_hi = w_r;
                o_lo = w_q;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/muldiv_engine.sv
// Multiply/divide responder: accepts a request, occupies the slot for a
// fixed number of cycles, then presents {HI, LO} until consumed.
module muldiv_engine
    import muldiv_pkg::*;
#(
    parameter int MUL_CYCLES = MUL_CYCLES_DEF,
    parameter int DIV_CYCLES = DIV_CYCLES_DEF,
    parameter int CNT_W      = CNT_W_DEF
) (
    input  logic   clk,
    input  logic   reset_n,
    muldiv_if.slave bus
);

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_cnt;
    logic [31:0]      r_hi;
    logic [31:0]      r_lo;
    logic [31:0]      r_res0;
    logic [31:0]      r_res1;
    logic             w_op_ok;
    logic             w_accept;
    logic             w_finish;
    logic [31:0]      w_hi;
    logic [31:0]      w_lo;

    assign w_op_ok  = (bus.in_op == OP_MUL) || (bus.in_op == OP_DIV);
    assign w_accept = (r_state == IDLE) && bus.in_valid && w_op_ok;
    assign w_finish = (r_state == BUSY) && (r_cnt == '0);

    muldiv_arith u_arith (
        .i_a    (bus.in_src0),
        .i_b    (bus.in_src1),
        .i_op   (bus.in_op),
        .i_sign (bus.in_sign),
        .o_hi   (w_hi),
        .o_lo   (w_lo)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: if (w_accept) w_next = BUSY;
            BUSY: if (r_cnt == '0) w_next = DONE;
            DONE: if (bus.out_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (w_accept) begin
            r_cnt <= (bus.in_op == OP_MUL) ? CNT_W'(MUL_CYCLES - 1)
                                           : CNT_W'(DIV_CYCLES - 1);
        end else if ((r_state == BUSY) && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    // Result is computed at acceptance; the delay only models occupancy.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (w_accept) begin
            r_hi <= w_hi;
            r_lo <= w_lo;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_res0 <= '0;
            r_res1 <= '0;
        end else if (w_finish) begin
            r_res0 <= r_lo;
            r_res1 <= r_hi;
        end
    end

    assign bus.in_ready  = (r_state == IDLE);
    assign bus.out_valid = (r_state == DONE);
    assign bus.out_res0  = r_res0;
    assign bus.out_res1  = r_res1;

endmodule

// File: tb/tb_muldiv_engine.sv
// Scoreboard bench for muldiv_engine: the driver queues expected results,
// a monitor checks value and latency at each rising out_valid.
module tb_muldiv_engine;
    import muldiv_pkg::*;

    typedef struct {
        logic [63:0] res;
        int          due;
        string       name;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t q[$];

    muldiv_if bus ();

    muldiv_engine #(
        .MUL_CYCLES (5),
        .DIV_CYCLES (10),
        .CNT_W      (4)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    // Monitor
    initial begin
        logic prev;
        exp_t it;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                prev = 1'b0;
            end else begin
                if (bus.out_valid && !prev) begin
                    if (q.size() == 0) begin
                        chk("unexpected_out_valid", 64'd1, 64'd0);
                    end else begin
                        it = q.pop_front();
                        chk(it.name, {bus.out_res1, bus.out_res0}, it.res);
                        chk({it.name, "_lat"}, 64'(cyc), 64'(it.due));
                    end
                end
                prev = bus.out_valid;
            end
        end
    end

    task automatic issue(input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] op, input logic s,
                         input logic [63:0] exp, input int n,
                         input string nm);
        @(negedge clk);
        bus.in_src0  = a;
        bus.in_src1  = b;
        bus.in_op    = op;
        bus.in_sign  = s;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        q.push_back('{exp, cyc + n, nm});
    endtask

    task automatic wait_done(input string nm);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) chk({nm, "_timeout"}, 64'd0, 64'd1);
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input logic [1:0] op, input logic s,
                          input logic [63:0] exp, input string nm);
        issue(a, b, op, s, exp, (op == OP_MUL) ? 5 : 10, nm);
        @(negedge clk);
        chk({nm, "_busy_rdy"}, 64'(bus.in_ready), 64'd0);
        wait_done(nm);
        @(negedge clk);
        chk({nm, "_idle_rdy"}, 64'(bus.in_ready), 64'd1);
        chk({nm, "_idle_vld"}, 64'(bus.out_valid), 64'd0);
    endtask

    initial begin
        reset_n       = 1'b0;
        bus.in_src0   = '0;
        bus.in_src1   = '0;
        bus.in_op     = OP_NONE;
        bus.in_sign   = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        chk("rst_vld", 64'(bus.out_valid), 64'd0);
        chk("rst_res", {bus.out_res1, bus.out_res0}, 64'd0);
        #19;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("rst_rdy", 64'(bus.in_ready), 64'd1);

        // 1-3: multiply and divide
        run_op(32'hFFFF_FFFE, 32'h3, OP_MUL, 1'b1,
               64'hFFFF_FFFF_FFFF_FFFA, "smul");
        run_op(32'hFFFF_FFFE, 32'h3, OP_MUL, 1'b0,
               64'h0000_0002_FFFF_FFFA, "umul");
        run_op(32'hFFFF_FFF9, 32'h2, OP_DIV, 1'b1,
               64'hFFFF_FFFF_FFFF_FFFD, "sdiv_m7_2");
        run_op(32'h7, 32'h0, OP_DIV, 1'b0,
               64'h0000_0007_FFFF_FFFF, "udiv_by0");
        run_op(32'h7, 32'hFFFF_FFFE, OP_DIV, 1'b1,
               64'h0000_0001_FFFF_FFFD, "sdiv_7_m2");
        run_op(32'hFFFF_FFFB, 32'h0, OP_DIV, 1'b1,
               64'hFFFF_FFFB_FFFF_FFFF, "sdiv_by0");
        run_op(32'd100, 32'd7, OP_DIV, 1'b0,
               64'h0000_0002_0000_000E, "udiv_100_7");

        // 4: overflow, then ignored op codes
        run_op(32'h8000_0000, 32'hFFFF_FFFF, OP_DIV, 1'b1,
               64'h0000_0000_8000_0000, "sdiv_ovf");
        @(negedge clk);
        bus.in_op    = OP_NONE;
        bus.in_valid = 1'b1;
        @(negedge clk);
        chk("opnone_rdy", 64'(bus.in_ready), 64'd1);
        bus.in_op = 2'b11;
        @(negedge clk);
        chk("op11_rdy", 64'(bus.in_ready), 64'd1);
        bus.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("op_ignored_vld", 64'(bus.out_valid), 64'd0);

        // 5: backpressure in DONE and a request pulsed during BUSY
        bus.out_ready = 1'b0;
        issue(32'h0001_0000, 32'h0001_0000, OP_MUL, 1'b0,
              64'h0000_0001_0000_0000, 5, "hold_mul");
        @(negedge clk);
        bus.in_src0  = 32'd100;
        bus.in_src1  = 32'd3;
        bus.in_op    = OP_DIV;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        wait_done("hold_mul");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("hold_vld", 64'(bus.out_valid), 64'd1);
            chk("hold_rdy", 64'(bus.in_ready), 64'd0);
            chk("hold_res", {bus.out_res1, bus.out_res0},
                64'h0000_0001_0000_0000);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("hold_release_rdy", 64'(bus.in_ready), 64'd1);
        repeat (12) @(negedge clk);
        chk("busy_pulse_dropped", 64'(bus.out_valid), 64'd0);

        // 6: async reset mid-BUSY
        issue(32'd9, 32'd2, OP_DIV, 1'b0, 64'h0000_0001_0000_0004,
              10, "lost_div");
        @(negedge clk);
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        q.delete();
        chk("midrst_vld", 64'(bus.out_valid), 64'd0);
        chk("midrst_res", {bus.out_res1, bus.out_res0}, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("midrst_rdy", 64'(bus.in_ready), 64'd1);
        run_op(32'd3, 32'd4, OP_MUL, 1'b0, 64'd12, "mul_3x4");

        repeat (4) @(negedge clk);
        chk("queue_empty", 64'(q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

endmodule
